// File: rtl/pool_engine.sv
// pool_engine: 2x2/stride-2 max/average pooling per channel over a shared memory port, optional ReLU clamp.
// Latency: 5 cycles per output (4 reads, 1 write); no backpressure, memory answers within the read cycle.
module pool_engine #(
    parameter int         DW       = 20,
    parameter int         IMG_W    = 64,
    parameter int         AW       = 12,
    parameter int         NCH      = 1,
    parameter logic [2:0] CSEL_RD0 = 3'd1,
    parameter logic [2:0] CSEL_WR0 = 3'd3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          relu,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int RW  = $clog2(IMG_W) - 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [RW-1:0]        col_q, col_d;
    logic [1:0]           ph_q, ph_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic                 mode_q, mode_d;
    logic                 relu_q, relu_d;
    logic signed [DW+1:0] acc_q, acc_d;
    logic signed [DW+1:0] rd_ext;
    logic [DW-1:0]        pool_res;

    assign rd_ext = {{2{cdata_rd[DW-1]}}, cdata_rd};

    // Max mode keeps the winner sign-extended in acc, so both modes share one register.
    always_comb begin
        pool_res = mode_q ? acc_q[DW+1:2] : acc_q[DW-1:0];
        if (relu_q && pool_res[DW-1]) begin
            pool_res = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ph_q    <= '0;
            ch_q    <= '0;
            mode_q  <= 1'b0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ph_q    <= ph_d;
            ch_q    <= ch_d;
            mode_q  <= mode_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        ph_d     = ph_q;
        ch_d     = ch_q;
        mode_d   = mode_q;
        relu_d   = relu_q;
        acc_d    = acc_q;
        busy     = 1'b0;
        done     = 1'b0;
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = 3'd0;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    relu_d  = relu;
                    row_d   = '0;
                    col_d   = '0;
                    ph_d    = '0;
                    ch_d    = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                crd      = 1'b1;
                csel     = CSEL_RD0 + 3'(ch_q);
                // Phase bit 0 walks the column, bit 1 the row: TL, TR, BL, BR.
                caddr_rd = AW'({row_q, ph_q[1], col_q, ph_q[0]});
                ph_d     = ph_q + 2'd1;
                if (ph_q == 2'd0) begin
                    acc_d = rd_ext;
                end else if (mode_q) begin
                    acc_d = acc_q + rd_ext;
                end else if ($signed(cdata_rd) > $signed(acc_q[DW-1:0])) begin
                    acc_d = rd_ext;
                end
                if (ph_q == 2'd3) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = CSEL_WR0 + 3'(ch_q);
                caddr_wr = AW'({row_q, col_q});
                cdata_wr = pool_res;
                state_d  = S_RD;
                col_d    = col_q + 1'b1;
                if (&col_q) begin
                    row_d = row_q + 1'b1;
                    if (&row_q) begin
                        if (ch_q == CHW'(NCH - 1)) begin
                            state_d = S_FIN;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pool_engine.sv
// Randomised scoreboard bench for pool_engine (two channels, 64x64 map) with a window-level reference model.
module tb_pool_engine;

    localparam int DW      = 20;
    localparam int IMG_W   = 64;
    localparam int AW      = 12;
    localparam int NCH     = 2;
    localparam int HW      = IMG_W / 2;
    localparam int NO      = HW * HW;
    localparam int RUN_LEN = NCH * NO * 5 + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic          relu;
    logic          busy;
    logic          done;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    pool_engine #(
        .DW(DW), .IMG_W(IMG_W), .AW(AW), .NCH(NCH),
        .CSEL_RD0(3'd1), .CSEL_WR0(3'd3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .relu(relu),
        .busy(busy), .done(done), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } xact_t;

    xact_t         exp_rd[$];
    xact_t         exp_wr[$];
    logic [DW-1:0] mem [NCH][IMG_W*IMG_W];
    logic [DW-1:0] l1  [NCH][NO];
    int            checks   = 0;
    int            errors   = 0;
    int            busy_cnt = 0;
    int            wr_cnt   = 0;
    int            done_cnt = 0;
    int            busy0, wr0, done0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference: each output is the max/floor-average of its 2x2 window, then optional clamp.
    task automatic plan(input bit m, input bit rl);
        int    a[4];
        int    v[4];
        int    r, c, best, sum, res;
        xact_t x;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < NO; k++) begin
                r = 2 * (k / HW);
                c = 2 * (k % HW);
                a[0] = r * IMG_W + c;
                a[1] = r * IMG_W + c + 1;
                a[2] = (r + 1) * IMG_W + c;
                a[3] = (r + 1) * IMG_W + c + 1;
                sum = 0;
                for (int i = 0; i < 4; i++) begin
                    v[i]   = sx(mem[ch][a[i]]);
                    sum   += v[i];
                    x.sel  = 3'(1 + ch);
                    x.addr = AW'(a[i]);
                    x.dat  = '0;
                    exp_rd.push_back(x);
                end
                best = v[0];
                for (int i = 1; i < 4; i++) if (v[i] > best) best = v[i];
                res = m ? (sum >>> 2) : best;
                if (rl && res < 0) res = 0;
                x.sel  = 3'(3 + ch);
                x.addr = AW'(k);
                x.dat  = DW'(res);
                exp_wr.push_back(x);
            end
        end
    endtask

    task automatic fill(input int kind);
        for (int ch = 0; ch < NCH; ch++) begin
            for (int a = 0; a < IMG_W * IMG_W; a++) begin
                case (kind)
                    0:       mem[ch][a] = (ch == 0) ? DW'(a) : DW'($urandom);
                    1:       mem[ch][a] = DW'($urandom);
                    default: mem[ch][a] = DW'(int'($urandom_range(7, 0)) - 4);
                endcase
            end
        end
        if (kind == 1) begin
            mem[0][0]  = 20'hFFFFD;
            mem[0][1]  = 20'hFFFFF;
            mem[0][64] = 20'hFFFFE;
            mem[0][65] = 20'hFFFFC;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_crd"}, crd, 0);
        check({tag, "_cwr"}, cwr, 0);
        check({tag, "_csel"}, csel, 0);
        check({tag, "_caddr_rd"}, caddr_rd, 0);
        check({tag, "_caddr_wr"}, caddr_wr, 0);
        check({tag, "_cdata_wr"}, cdata_wr, 0);
    endtask

    task automatic mark;
        busy0 = busy_cnt;
        wr0   = wr_cnt;
        done0 = done_cnt;
    endtask

    task automatic kick(input bit m, input bit rl);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = m;
        relu  = rl;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'($urandom);
        relu  = 1'($urandom);
        mark();
    endtask

    // Returns at the falling edge of the done cycle; optionally pulses start mid-run.
    task automatic wait_done(input bit poke);
        int n = 0;
        while (n < RUN_LEN + 20) begin
            @(negedge clk);
            n++;
            if (done) break;
            start = poke && (n % 997 == 13);
            mode  = 1'($urandom);
            relu  = 1'($urandom);
        end
        start = 1'b0;
        check("run_len", n, RUN_LEN);
        check("busy_cycles", busy_cnt - busy0, RUN_LEN - 1);
        check("busy_at_done", busy, 0);
        check("wr_count", wr_cnt - wr0, NCH * NO);
        check("wr_left", exp_wr.size(), 0);
        check("rd_left", exp_rd.size(), 0);
    endtask

    task automatic post_run;
        @(posedge clk);
        #1;
        check("done_pulses", done_cnt - done0, 1);
        check("done_low", done, 0);
        check("csel_after", csel, 0);
    endtask

    // Monitor: serves memory reads and pops the scoreboard on every strobe.
    always @(negedge clk) begin
        xact_t e;
        int    idx;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        cdata_rd = DW'($urandom);
        if (crd) begin
            check("rd_expected", 32'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                check("rd_csel", csel, e.sel);
                check("rd_addr", caddr_rd, e.addr);
            end
            idx = int'(csel) - 1;
            if (idx >= 0 && idx < NCH) cdata_rd = mem[idx][caddr_rd];
        end
        if (cwr) begin
            check("wr_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                check("wr_csel", csel, e.sel);
                check("wr_addr", caddr_wr, e.addr);
                check("wr_data", cdata_wr, e.dat);
            end
            idx = int'(csel) - 3;
            if (idx >= 0 && idx < NCH) l1[idx][caddr_wr[$clog2(NO)-1:0]] = cdata_wr;
            wr_cnt++;
        end
        if (!crd && !cwr) check("csel_idle", csel, 0);
    end

    initial begin
        int ks[5];
        bit m, rl;
        ks    = '{0, 1, 31, 32, 1023};
        reset = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        relu  = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        fill(0);
        plan(1'b0, 1'b0);
        kick(1'b0, 1'b0);
        wait_done(1'b0);
        post_run();
        foreach (ks[i]) begin
            check("ramp_max", l1[0][ks[i]], (2 * (ks[i] / HW) + 1) * IMG_W + 2 * (ks[i] % HW) + 1);
        end

        plan(1'b1, 1'b0);
        kick(1'b1, 1'b0);
        wait_done(1'b0);
        post_run();
        check("ramp_avg_first", l1[0][0], 20'h00020);
        check("ramp_avg_last", l1[0][NO-1], 20'h00FDE);

        fill(1);
        plan(1'b0, 1'b0);
        kick(1'b0, 1'b0);
        wait_done(1'b0);
        post_run();
        check("win_max", l1[0][0], 20'hFFFFF);

        plan(1'b1, 1'b0);
        kick(1'b1, 1'b0);
        wait_done(1'b1);
        // start held through the FIN cycle (ignored) and the following IDLE cycle (accepted).
        plan(1'b0, 1'b1);
        start = 1'b1;
        mode  = 1'b0;
        relu  = 1'b1;
        @(posedge clk);
        #1;
        check("fin_start_busy", busy, 0);
        check("fin_start_crd", crd, 0);
        check("poke_done_pulses", done_cnt - done0, 1);
        check("win_avg", l1[0][0], 20'hFFFFD);
        @(posedge clk);
        #1;
        start = 1'b0;
        mark();
        wait_done(1'b0);
        post_run();
        check("win_relu", l1[0][0], 20'h00000);

        fill(2);
        m  = 1'($urandom);
        rl = 1'($urandom);
        plan(m, rl);
        kick(m, rl);
        repeat (503) @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_wr_cnt", wr_cnt - wr0, 100);
        exp_rd.delete();
        exp_wr.delete();
        repeat (3) @(negedge clk);
        check("abort_hold_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m  = 1'($urandom);
        rl = 1'($urandom);
        plan(m, rl);
        kick(m, rl);
        wait_done(1'b0);
        post_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
